fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  decode stage cannot accept the presented instruction this cycle.
REQ-005 SHALL have port npc_op  input  2  next-PC select for the presented instruction: 00 seq, 01 beq, 10 j, 11 jr.
REQ-006 SHALL have port zero  input  1  branch condition for npc_op 01.
REQ-007 SHALL have port imm26  input  26  jump index; bits [15:0] are the branch offset.
REQ-008 SHALL have port ra  input  32  register target for npc_op 11.
REQ-009 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-010 SHALL have port imem_addr  output  32  fetch address; bits [1:0] always 0.
REQ-011 SHALL have port imem_gnt  input  1  memory accepted the request this cycle.
REQ-012 SHALL have port imem_rvalid  input  1  fetch data valid.
REQ-013 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-014 SHALL have port inst_valid  output  1  inst/pc/pc_4 hold a valid instruction.
REQ-015 SHALL have ports inst, pc, pc_4  output  32 each  presented instruction, its address, address+4.

Function
REQ-016 SHALL implement states S_REQ, S_WAIT, S_HOLD.
REQ-017 S_REQ: imem_req=1, imem_addr=fetch PC; on imem_gnt -> S_WAIT; request and address stable until granted.
REQ-018 S_WAIT: imem_req=0; on imem_rvalid capture imem_rdata into inst, PC into pc -> S_HOLD; imem_rvalid outside S_WAIT SHALL be ignored.
REQ-019 S_HOLD: inst_valid=1; instruction consumed when stall=0; on consumption fetch PC <= next PC, -> S_REQ; while stall=1 all outputs hold.
REQ-020 Next PC: 00 pc+4; 01 zero ? pc+4+(sext(imm26[15:0])<<2) : pc+4; 10 {pc[31:28],imm26,2'b00}; 11 {ra[31:2],2'b00}.
REQ-021 All address arithmetic SHALL be 32-bit modulo 2^32; pc_4 of 32'hFFFF_FFFC is 32'h0000_0000.
REQ-022 npc_op, zero, imm26, ra SHALL be sampled only in the consuming cycle; ignored otherwise.
REQ-023 Minimum consume-to-next-inst_valid latency SHALL be 3 cycles (gnt and rvalid each in first cycle possible).

Reset
REQ-024 Reset SHALL force S_REQ, fetch PC=RESET_PC, inst_valid=0, inst=0, pc=RESET_PC, pc_4=RESET_PC+4, pending state cleared.
REQ-025 Reset asserted mid-operation (any state, incl. outstanding S_WAIT) SHALL take priority; stale response discarded per REQ-018.

Configuration
REQ-026 Macro FETCH_DELAY_SLOT_EN SHALL enable MIPS branch-delay-slot behaviour.
REQ-027 With macro: taken redirect stores target in pending register; next fetch is pc+4 (delay slot); on consuming the delay slot, fetch PC <= pending target and pending clears; redirect decoded in a delay slot SHALL be ignored (sequential).
REQ-028 Without macro: redirect takes effect on the immediately following fetch; no pending register exists.

Structure
REQ-029 Shared package fetch_pkg SHALL hold state encoding, npc_op encodings (NPC_SEQ, NPC_BEQ, NPC_J, NPC_JR) and default RESET_PC.
REQ-030 Next-PC computation SHALL be a combinational sub-module fetch_npc_calc; FSM, registers and handshake remain in fetch_ctrl.

Verification
REQ-031 Reset, gnt and rvalid each 1 cycle later -> imem_addr 32'h0000_3000, then inst_valid=1, pc 32'h0000_3000, pc_4 32'h0000_3004.
REQ-032 pc 32'h0000_3008, npc_op 01, zero 1, imm16 16'hFFFE -> next imem_addr 32'h0000_3004; zero 0 -> 32'h0000_300C.
REQ-033 pc 32'hA000_0010, npc_op 10, imm26 26'h000_0C40 -> next imem_addr 32'hA000_3100; npc_op 11, ra 32'h0000_3017 -> 32'h0000_3014.
REQ-034 stall held 4 cycles in S_HOLD, gnt withheld 3 cycles in S_REQ -> outputs and imem_addr unchanged, no extra fetch.
REQ-035 Reset in S_WAIT, rvalid next cycle -> response dropped, refetch 32'h0000_3000.
REQ-036 With FETCH_DELAY_SLOT_EN, j at 32'h0000_3000 to 32'h0000_3040 -> fetches 32'h0000_3004 then 32'h0000_3040; without macro -> 32'h0000_3040 directly.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, next-PC select codes, default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fetch_npc_calc.sv
// Combinational next-PC calculation for the instruction presented to decode.
// o_redirect marks a taken control transfer (beq taken, j, jr).
module fetch_npc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_npc_op,
  input  logic        i_zero,
  input  logic [25:0] i_imm26,
  input  logic [31:0] i_ra,
  output logic [31:0] o_pc_4,
  output logic [31:0] o_npc,
  output logic        o_redirect
);

  logic [31:0] w_br_off;

  assign w_br_off = {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};

  always_comb begin
    o_pc_4     = i_pc + 32'd4;
    o_npc      = o_pc_4;
    o_redirect = 1'b0;
    case (i_npc_op)
      NPC_BEQ: begin
        if (i_zero) begin
          o_npc      = o_pc_4 + w_br_off;
          o_redirect = 1'b1;
        end
      end
      NPC_J: begin
        o_npc      = {i_pc[31:28], i_imm26, 2'b00};
        o_redirect = 1'b1;
      end
      NPC_JR: begin
        o_npc      = i_ra & 32'hFFFF_FFFC;
        o_redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: request -> wait for data -> hold for decode, then advance PC.
// Define FETCH_DELAY_SLOT_EN for MIPS branch-delay-slot redirect behaviour.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        zero,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_4
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_fetch_pc, r_inst, r_pc;
  logic [31:0]  w_pc_4, w_npc, w_fetch_nxt;
  logic         w_redirect, w_capture, w_consume;

  fetch_npc_calc u_npc (
    .i_pc       (r_pc),
    .i_npc_op   (npc_op),
    .i_zero     (zero),
    .i_imm26    (imm26),
    .i_ra       (ra),
    .o_pc_4     (w_pc_4),
    .o_npc      (w_npc),
    .o_redirect (w_redirect)
  );

  assign w_capture = (r_state == S_WAIT) && imem_rvalid;
  assign w_consume = (r_state == S_HOLD) && !stall;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    inst_valid  = 1'b0;
    case (r_state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (!stall) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

`ifdef FETCH_DELAY_SLOT_EN
  logic        r_pend_vld;
  logic [31:0] r_pend_pc;

  // A pending target means the instruction being consumed is a delay slot; its own redirect is dropped.
  always_comb begin
    if (r_pend_vld) w_fetch_nxt = r_pend_pc;
    else            w_fetch_nxt = w_pc_4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_vld <= 1'b0;
      r_pend_pc  <= 32'd0;
    end else if (w_consume) begin
      if (r_pend_vld) begin
        r_pend_vld <= 1'b0;
      end else if (w_redirect) begin
        r_pend_vld <= 1'b1;
        r_pend_pc  <= w_npc;
      end
    end
  end
`else
  assign w_fetch_nxt = w_redirect ? w_npc : w_pc_4;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_inst     <= 32'd0;
      r_pc       <= RESET_PC;
    end else begin
      if (w_capture) begin
        r_inst <= imem_rdata;
        r_pc   <= r_fetch_pc;
      end
      if (w_consume) r_fetch_pc <= w_fetch_nxt;
    end
  end

  assign imem_addr = r_fetch_pc & 32'hFFFF_FFFC;
  assign inst      = r_inst;
  assign pc        = r_pc;
  assign pc_4      = w_pc_4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; expected fetch addresses are queued at consume time and checked at request time.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, zero;
  logic [1:0]  npc_op;
  logic [25:0] imm26;
  logic [31:0] ra;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid;
  logic [31:0] inst, pc, pc_4;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_op      (npc_op),
    .zero        (zero),
    .imm26       (imm26),
    .ra          (ra),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .pc          (pc),
    .pc_4        (pc_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    npc_op = 2'($urandom);
    zero   = 1'($urandom);
    imm26  = 26'($urandom);
    ra     = $urandom;
  endtask

  // Serve one fetch: gd cycles of withheld grant, rd idle cycles before rvalid.
  task automatic fetch(input int gd, input int rd);
    logic [31:0] a;
    int w;
    w = 0;
    while (imem_req !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk1("req_seen", imem_req, 1'b1);
    a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk("imem_addr", imem_addr, a);
    repeat (gd) begin
      @(negedge clk);
      chk1("req_hold", imem_req, 1'b1);
      chk("addr_hold", imem_addr, a);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk1("wait_req_low", imem_req, 1'b0);
    repeat (rd) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = a ^ 32'h5A5A_0000;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk1("inst_valid", inst_valid, 1'b1);
    chk("inst", inst, a ^ 32'h5A5A_0000);
    chk("pc", pc, a);
    chk("pc_4", pc_4, a + 32'd4);
    cur_pc = a;
  endtask

  task automatic consume(input logic [1:0] op, input logic z, input logic [25:0] imm,
                         input logic [31:0] ra_v, input int stall_n, input logic [31:0] nxt);
    repeat (stall_n) begin
      scramble();
      @(negedge clk);
      chk1("stall_valid", inst_valid, 1'b1);
      chk("stall_pc", pc, cur_pc);
      chk("stall_inst", inst, cur_pc ^ 32'h5A5A_0000);
      chk1("stall_no_req", imem_req, 1'b0);
    end
    stall  = 1'b0;
    npc_op = op;
    zero   = z;
    imm26  = imm;
    ra     = ra_v;
    exp_q.push_back(nxt);
    @(negedge clk);
    stall = 1'b1;
    scramble();
    chk1("consumed", inst_valid, 1'b0);
  endtask

  task automatic redir(input logic [1:0] op, input logic z, input logic [25:0] imm,
                       input logic [31:0] ra_v, input logic [31:0] target);
`ifdef FETCH_DELAY_SLOT_EN
    consume(op, z, imm, ra_v, 0, cur_pc + 32'd4);
    fetch(0, 0);
    consume(NPC_J, 1'b1, 26'h3FF_FFFF, 32'hFFFF_FFF0, 0, target);
`else
    consume(op, z, imm, ra_v, 0, target);
`endif
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; stall = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    npc_op = NPC_SEQ; zero = 1'b0; imm26 = 26'd0; ra = 32'd0; cur_pc = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_pc_4", pc_4, 32'h0000_3004);
    reset = 1'b0;
    exp_q.push_back(32'h0000_3000);
    fetch(1, 1);

    consume(NPC_SEQ, 1'b0, 26'd0, 32'd0, 0, 32'h0000_3004);
    fetch(0, 0);
    consume(NPC_SEQ, 1'b0, 26'd0, 32'd0, 4, 32'h0000_3008);
    fetch(3, 0);
    redir(NPC_BEQ, 1'b1, 26'h000_FFFE, 32'd0, 32'h0000_3004);
    fetch(0, 0);
    consume(NPC_SEQ, 1'b0, 26'd0, 32'd0, 0, 32'h0000_3008);
    fetch(0, 2);
    consume(NPC_BEQ, 1'b0, 26'h000_FFFE, 32'd0, 0, 32'h0000_300C);
    fetch(0, 0);
    redir(NPC_JR, 1'b0, 26'd0, 32'h0000_3017, 32'h0000_3014);
    fetch(0, 0);
    redir(NPC_JR, 1'b0, 26'd0, 32'hA000_0010, 32'hA000_0010);
    fetch(0, 0);
    redir(NPC_J, 1'b0, 26'h000_0C40, 32'd0, 32'hA000_3100);
    fetch(0, 0);
    redir(NPC_JR, 1'b0, 26'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    fetch(0, 0);
    chk("pc4_wrap", pc_4, 32'h0000_0000);
    consume(NPC_SEQ, 1'b0, 26'd0, 32'd0, 0, 32'h0000_0000);
    fetch(0, 0);

    // Reset while a response is outstanding; the late rvalid must be dropped.
    consume(NPC_SEQ, 1'b0, 26'd0, 32'd0, 0, 32'h0000_0004);
    a = exp_q.pop_front();
    chk("pre_rst_addr", imem_addr, a);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk1("drop_inst_valid", inst_valid, 1'b0);
    chk("drop_inst", inst, 32'd0);
    chk("drop_pc", pc, 32'h0000_3000);
    chk("drop_pc_4", pc_4, 32'h0000_3004);
    exp_q.push_back(32'h0000_3000);
    fetch(0, 1);

    redir(NPC_J, 1'b0, 26'h000_0C10, 32'd0, 32'h0000_3040);
    fetch(0, 0);
    chk("qsize_end", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
